// File: rtl/draw_controller.sv
// Rectangle-fill / screen-clear pixel sequencer: emits one framebuffer write per cycle
// in raster order, with a pending-draw slot so a draw requested during a clear follows it.
module draw_controller #(
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear_req,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  input  logic [2:0] color_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] color,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] XM = 8'(XMAX);
  localparam logic [6:0] YM = 7'(YMAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_DRAW,
    S_DONE
  } state_t;

  state_t     r_state, w_next;
  logic [7:0] r_x, w_x;
  logic [6:0] r_y, w_y;
  logic [2:0] r_color, w_color;
  logic       r_plot, r_done, r_pend, w_pend, w_cap;
  logic [7:0] r_x0, r_w, r_ex, w_ex;
  logic [6:0] r_y0, r_h, r_ey, w_ey;
  logic [2:0] r_col;
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  logic       w_degen;

  // End coordinates are computed one bit wider than the screen so x0+w-1 cannot wrap
  always_comb begin
    w_sum_x = {1'b0, r_x0} + {1'b0, r_w} - 9'd1;
    w_sum_y = {1'b0, r_y0} + {1'b0, r_h} - 8'd1;
    w_ex    = (w_sum_x > {1'b0, XM}) ? XM : w_sum_x[7:0];
    w_ey    = (w_sum_y > {1'b0, YM}) ? YM : w_sum_y[6:0];
    w_degen = (r_w == 8'd0) || (r_h == 7'd0) || (r_x0 > XM) || (r_y0 > YM);
  end

  always_comb begin
    w_next  = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_color = r_color;
    w_pend  = r_pend;
    w_cap   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_next  = S_CLEAR;
          w_x     = 8'd0;
          w_y     = 7'd0;
          w_color = 3'd0;
          if (start) begin
            w_cap  = 1'b1;
            w_pend = 1'b1;
          end
        end else if (start) begin
          w_cap  = 1'b1;
          w_next = S_LOAD;
        end
      end
      S_CLEAR: begin
        if (start) begin
          w_cap  = 1'b1;
          w_pend = 1'b1;
        end
        if (r_x == XM && r_y == YM) begin
          w_next = (r_pend || start) ? S_LOAD : S_DONE;
          w_pend = 1'b0;
        end else if (r_x == XM) begin
          w_x = 8'd0;
          w_y = r_y + 7'd1;
        end else begin
          w_x = r_x + 8'd1;
        end
      end
      S_LOAD: begin
        if (w_degen) begin
          w_next = S_DONE;
        end else begin
          w_next  = S_DRAW;
          w_x     = r_x0;
          w_y     = r_y0;
          w_color = r_col;
        end
      end
      S_DRAW: begin
        if (r_x == r_ex && r_y == r_ey) begin
          w_next = S_DONE;
        end else if (r_x == r_ex) begin
          w_x = r_x0;
          w_y = r_y + 7'd1;
        end else begin
          w_x = r_x + 8'd1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= 8'd0;
      r_y     <= 7'd0;
      r_color <= 3'd0;
      r_plot  <= 1'b0;
      r_done  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_x     <= w_x;
      r_y     <= w_y;
      r_color <= w_color;
      r_plot  <= (w_next == S_CLEAR) || (w_next == S_DRAW);
      r_done  <= (w_next == S_DONE);
      r_pend  <= w_pend;
    end
  end

  // Captured operation parameters and the clipped end point
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x0  <= 8'd0;
      r_y0  <= 7'd0;
      r_w   <= 8'd0;
      r_h   <= 7'd0;
      r_col <= 3'd0;
      r_ex  <= 8'd0;
      r_ey  <= 7'd0;
    end else begin
      if (w_cap) begin
        r_x0  <= x0;
        r_y0  <= y0;
        r_w   <= w;
        r_h   <= h;
        r_col <= color_in;
      end
      if (r_state == S_LOAD) begin
        r_ex <= w_ex;
        r_ey <= w_ey;
      end
    end
  end

  assign x     = r_x;
  assign y     = r_y;
  assign color = r_color;
  assign plot  = r_plot;
  assign done  = r_done;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_draw_controller.sv
// Directed bench for draw_controller: rectangle draws, full clear, clipping,
// degenerate requests, combined clear+draw, ignored requests and mid-draw reset.
module tb_draw_controller;
  logic       clk = 1'b0;
  logic       reset, start, clear_req;
  logic [7:0] x0, w;
  logic [6:0] y0, h;
  logic [2:0] color_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;
  logic       plot, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  draw_controller #(.XMAX(159), .YMAX(119)) dut (
    .clk(clk), .reset(reset), .start(start), .clear_req(clear_req),
    .x0(x0), .y0(y0), .w(w), .h(h), .color_in(color_in),
    .x(x), .y(y), .color(color), .plot(plot), .busy(busy), .done(done)
  );

  // Pulses start (and optionally clear_req) for one cycle, then scrambles the
  // parameter inputs so any late sampling would show up as wrong pixels.
  task automatic pulse_req(input logic [7:0] ax, input logic [6:0] ay, input logic [7:0] aw,
                           input logic [6:0] ah, input logic [2:0] ac, input logic st, input logic clr);
    @(negedge clk);
    x0 = ax; y0 = ay; w = aw; h = ah; color_in = ac;
    start = st; clear_req = clr;
    @(negedge clk);
    start = 1'b0; clear_req = 1'b0;
    x0 = 8'hAA; y0 = 7'h55; w = 8'hFF; h = 7'h7F; color_in = 3'd6;
  endtask

  // Walks the full clear sequence starting at the current negedge; returns the
  // first deviating index (or -1) and the outputs seen there.
  task automatic scan_clear(output int bad, output logic [20:0] got);
    bad = -1;
    got = '0;
    for (int i = 0; i < 19200; i++) begin
      if (i > 0) @(negedge clk);
      if (bad < 0 && ({plot, busy, done, x, y, color} !==
                      {1'b1, 1'b1, 1'b0, 8'(i % 160), 7'(i / 160), 3'd0})) begin
        bad = i;
        got = {plot, busy, done, x, y, color};
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; clear_req = 1'b0;
    x0 = '0; y0 = '0; w = '0; h = '0; color_in = '0;
    #1;
    tests++;
    if ({x, y, color, plot, busy, done} !== 21'd0) begin
      fails++; $display("FAIL reset_outputs got=%h want=0", {x, y, color, plot, busy, done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({x, y, color, plot, busy, done} !== 21'd0) begin
      fails++; $display("FAIL idle_after_reset got=%h want=0", {x, y, color, plot, busy, done});
    end
  endtask

  task automatic test_draw;
    pulse_req(8'd10, 7'd20, 8'd3, 7'd2, 3'd5, 1'b1, 1'b0);
    tests++;
    if ({plot, busy, done} !== 3'b010) begin
      fails++; $display("FAIL draw_load plot/busy/done=%b want=010", {plot, busy, done});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests++;
      if ({plot, x, y, color} !== {1'b1, 8'(10 + i % 3), 7'(20 + i / 3), 3'd5}) begin
        fails++; $display("FAIL draw_pix%0d got p=%b (%0d,%0d) c=%0d want (%0d,%0d) c=5",
                          i, plot, x, y, color, 10 + i % 3, 20 + i / 3);
      end
    end
    @(negedge clk);
    tests++;
    if ({done, plot, busy} !== 3'b101) begin
      fails++; $display("FAIL draw_done done/plot/busy=%b want=101", {done, plot, busy});
    end
    @(negedge clk);
    tests++;
    if ({done, busy, plot} !== 3'b000) begin
      fails++; $display("FAIL draw_idle done/busy/plot=%b want=000", {done, busy, plot});
    end
  endtask

  task automatic test_clear;
    int bad;
    logic [20:0] got;
    pulse_req(8'd0, 7'd0, 8'd0, 7'd0, 3'd0, 1'b0, 1'b1);
    scan_clear(bad, got);
    tests++;
    if (bad !== -1) begin
      fails++; $display("FAIL clear_seq first bad index %0d got=%h want x=%0d y=%0d plot=1 busy=1",
                        bad, got, bad % 160, bad / 160);
    end
    @(negedge clk);
    tests++;
    if ({done, plot, busy} !== 3'b101) begin
      fails++; $display("FAIL clear_done done/plot/busy=%b want=101", {done, plot, busy});
    end
    @(negedge clk);
    tests++;
    if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL clear_idle done/busy=%b want=00", {done, busy});
    end
  endtask

  task automatic test_clip;
    logic [7:0] ex [4];
    logic [6:0] ey [4];
    ex = '{8'd158, 8'd159, 8'd158, 8'd159};
    ey = '{7'd118, 7'd118, 7'd119, 7'd119};
    pulse_req(8'd158, 7'd118, 8'd5, 7'd5, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({plot, x, y, color} !== {1'b1, ex[i], ey[i], 3'd2}) begin
        fails++; $display("FAIL clip_pix%0d got p=%b (%0d,%0d) c=%0d want (%0d,%0d) c=2",
                          i, plot, x, y, color, ex[i], ey[i]);
      end
    end
    @(negedge clk);
    tests++;
    if ({done, plot} !== 2'b10) begin
      fails++; $display("FAIL clip_done done/plot=%b want=10", {done, plot});
    end
  endtask

  task automatic test_degenerate;
    @(negedge clk);
    pulse_req(8'd20, 7'd20, 8'd0, 7'd4, 3'd1, 1'b1, 1'b0);
    tests++;
    if ({plot, done, busy} !== 3'b001) begin
      fails++; $display("FAIL w0_load plot/done/busy=%b want=001", {plot, done, busy});
    end
    @(negedge clk);
    tests++;
    if ({plot, done, x, y, color} !== {1'b0, 1'b1, 8'd159, 7'd119, 3'd2}) begin
      fails++; $display("FAIL w0_done got p=%b d=%b (%0d,%0d) c=%0d want d=1 (159,119) c=2",
                        plot, done, x, y, color);
    end
    pulse_req(8'd200, 7'd5, 8'd3, 7'd3, 3'd3, 1'b1, 1'b0);
    tests++;
    if ({plot, done} !== 2'b00) begin
      fails++; $display("FAIL x200_load plot/done=%b want=00", {plot, done});
    end
    @(negedge clk);
    tests++;
    if ({plot, done} !== 2'b01) begin
      fails++; $display("FAIL x200_done plot/done=%b want=01", {plot, done});
    end
    @(negedge clk);
  endtask

  task automatic test_clear_then_draw;
    int bad;
    logic [20:0] got;
    pulse_req(8'd5, 7'd6, 8'd2, 7'd2, 3'd7, 1'b1, 1'b1);
    scan_clear(bad, got);
    tests++;
    if (bad !== -1) begin
      fails++; $display("FAIL both_clear_seq first bad index %0d got=%h", bad, got);
    end
    @(negedge clk);
    tests++;
    if ({plot, done, busy} !== 3'b001) begin
      fails++; $display("FAIL both_load plot/done/busy=%b want=001", {plot, done, busy});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({plot, done, x, y, color} !== {1'b1, 1'b0, 8'(5 + i % 2), 7'(6 + i / 2), 3'd7}) begin
        fails++; $display("FAIL both_pix%0d got p=%b (%0d,%0d) c=%0d want (%0d,%0d) c=7",
                          i, plot, x, y, color, 5 + i % 2, 6 + i / 2);
      end
    end
    @(negedge clk);
    tests++;
    if ({done, plot} !== 2'b10) begin
      fails++; $display("FAIL both_done done/plot=%b want=10", {done, plot});
    end
    @(negedge clk);
    tests++;
    if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL both_idle done/busy=%b want=00", {done, busy});
    end
  endtask

  task automatic test_ignore_busy;
    pulse_req(8'd30, 7'd40, 8'd2, 7'd1, 3'd1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b1; clear_req = 1'b1; x0 = 8'd0; w = 8'd9;
    @(negedge clk);
    start = 1'b0; clear_req = 1'b0;
    tests++;
    if ({plot, x, y} !== {1'b1, 8'd31, 7'd40}) begin
      fails++; $display("FAIL ignore_pix got p=%b (%0d,%0d) want (31,40)", plot, x, y);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL ignore_done done=%b want=1", done);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, plot, done} !== 3'b000) begin
      fails++; $display("FAIL ignore_idle busy/plot/done=%b want=000", {busy, plot, done});
    end
  endtask

  task automatic test_reset_mid_draw;
    logic seen_done;
    pulse_req(8'd0, 7'd0, 8'd10, 7'd1, 3'd3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) @(negedge clk);
    tests++;
    if ({plot, x} !== {1'b1, 8'd2}) begin
      fails++; $display("FAIL mid_pix3 got p=%b x=%0d want p=1 x=2", plot, x);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({x, y, color, plot, busy, done} !== 21'd0) begin
      fails++; $display("FAIL mid_reset got=%h want=0", {x, y, color, plot, busy, done});
    end
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      seen_done = seen_done | done | plot;
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen_done = seen_done | done | plot;
    end
    tests++;
    if (seen_done !== 1'b0) begin
      fails++; $display("FAIL mid_no_done activity=%b want=0", seen_done);
    end
    pulse_req(8'd1, 7'd2, 8'd2, 7'd1, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if ({plot, x, y, color} !== {1'b1, 8'(1 + i), 7'd2, 3'd4}) begin
        fails++; $display("FAIL post_pix%0d got p=%b (%0d,%0d) c=%0d want (%0d,2) c=4",
                          i, plot, x, y, color, 1 + i);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL post_done done=%b want=1", done);
    end
  endtask

  initial begin
    test_reset();
    test_draw();
    test_clear();
    test_clip();
    test_degenerate();
    test_clear_then_draw();
    test_ignore_busy();
    test_reset_mid_draw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/draw_controller.md
DRAW_CONTROLLER -- requirements
Module: draw_controller

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have: start  in  1  one-cycle pulse; request a rectangle draw.
REQ-004 SHALL have: clear_req  in  1  one-cycle pulse; request a full-screen clear.
REQ-005 SHALL have: x0  in  8 and y0  in  7  rectangle top-left corner.
REQ-006 SHALL have: w  in  8 and h  in  7  rectangle width and height in pixels.
REQ-007 SHALL have: color_in  in  3  rectangle colour.
REQ-008 SHALL have: x  out  8, y  out  7, color  out  3  framebuffer write address and data.
REQ-009 SHALL have: plot  out  1  write strobe; x/y/color valid when high.
REQ-010 SHALL have: busy  out  1  high in every state except IDLE.
REQ-011 SHALL have: done  out  1  one-cycle pulse when an operation completes.
REQ-012 SHALL use parameters XMAX, default 159, last column; YMAX, default 119, last row.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, LOAD, DRAW, DONE.
REQ-014 IDLE: clear_req -> CLEAR; else start -> LOAD; else stay.
REQ-015 SHALL capture x0, y0, w, h, color_in on the start cycle; later input changes have no effect on the operation.
REQ-016 CLEAR: plot=1 and color=0 every cycle; x steps 0..XMAX, y steps 0..YMAX in raster order, x fastest; exactly (XMAX+1)*(YMAX+1) plots (19200 by default).
REQ-017 CLEAR: after the plot at (XMAX,YMAX) -> LOAD if a draw is pending, else DONE.
REQ-018 LOAD: one cycle, plot=0; compute ex=min(x0+w-1,XMAX) and ey=min(y0+h-1,YMAX) with 9-bit and 8-bit intermediates so there is no wrap.
REQ-019 LOAD: if w==0, h==0, x0>XMAX or y0>YMAX -> DONE with zero plots; else -> DRAW with x=x0, y=y0.
REQ-020 DRAW: plot=1 and color=captured colour every cycle; x runs x0..ex, then returns to x0 and y increments; after (ex,ey) -> DONE.
REQ-021 Draw latency: start sampled in cycle N gives LOAD in N+1 and first plot in N+2.
REQ-022 DONE: done=1 for exactly one cycle, plot=0, then -> IDLE.
REQ-023 start and clear_req in the same IDLE cycle: the clear runs first; the draw is latched as pending with its parameters captured; the draw runs after the clear; only one done pulse, after the draw.
REQ-024 start arriving during CLEAR SHALL set pending and capture parameters.
REQ-025 start or clear_req during LOAD, DRAW or DONE SHALL be ignored.
REQ-026 plot SHALL be 0 in IDLE, LOAD and DONE; x, y and color hold their last values when plot=0.
REQ-027 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-028 Reset asserted: state=IDLE; x=0, y=0, color=0, plot=0, busy=0, done=0; pending flag and captured parameters cleared.
REQ-029 Reset asserted mid-CLEAR or mid-DRAW SHALL abort the operation with no done pulse; after deassertion the block accepts start on the next edge.

Verification
REQ-030 Reset then start with x0=10, y0=20, w=3, h=2, color_in=5 -> plots at (10,20), (11,20), (12,20), (10,21), (11,21), (12,21), color=5; first plot 2 cycles after start; done one cycle after the last plot.
REQ-031 clear_req -> 19200 consecutive plots with color=0 from (0,0) to (159,119), then one done pulse; busy high throughout.
REQ-032 Clipping: x0=158, y0=118, w=5, h=5 -> exactly 4 plots: (158,118), (159,118), (158,119), (159,119).
REQ-033 Degenerate: w=0, or x0=200 -> zero plots, done exactly 2 cycles after start.
REQ-034 start and clear_req in the same cycle with a 2x2 rectangle -> 19200 clear plots, then LOAD, then 4 rectangle plots, then a single done pulse.
REQ-035 Reset asserted during DRAW after 3 plots -> all outputs 0 immediately, no done pulse; a new start then draws correctly.
